// File: rtl/instr_register_pipe.sv
// Handshaked instruction register file with a pipelined single-cycle ALU.
// Define IRP_DIV_EN to build the iterative signed DIV/MOD unit.
module instr_register_pipe #(
    parameter int OP_WIDTH = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            opcode,
    input  logic [OP_WIDTH-1:0]   operand_a,
    input  logic [OP_WIDTH-1:0]   operand_b,
    input  logic [AW-1:0]         write_pointer,
    input  logic [AW-1:0]         read_pointer,
    output logic [2:0]            rd_opcode,
    output logic [OP_WIDTH-1:0]   rd_operand_a,
    output logic [OP_WIDTH-1:0]   rd_operand_b,
    output logic [2*OP_WIDTH-1:0] rd_result,
    output logic                  rd_valid,
    output logic                  rd_error,
    output logic                  wr_done,
    output logic [AW-1:0]         wr_done_ptr
);
    localparam int W  = OP_WIDTH;
    localparam int RW = 2 * OP_WIDTH;
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    typedef struct packed {
        logic          vld;
        logic          err;
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [RW-1:0] res;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        stg_q, stg_d, entry_d, rd_e;
    logic [AW-1:0] stg_ptr_q, stg_ptr_d, wr_ptr;
    logic          wr_en;
    logic          wr_done_q, wr_done_d;
    logic [AW-1:0] wr_done_ptr_q, wr_done_ptr_d;
    logic [RW-1:0] a_ext, b_ext, alu_res;
    logic          alu_err, xfer, div_op, div_start;

    assign xfer   = in_valid && in_ready;
    assign div_op = (opcode == OP_DIV) || (opcode == OP_MOD);

    always_comb begin
        a_ext   = {{W{operand_a[W-1]}}, operand_a};
        b_ext   = {{W{operand_b[W-1]}}, operand_b};
        alu_res = '0;
        alu_err = 1'b0;
        unique case (opcode)
            OP_ZERO:  alu_res = '0;
            OP_PASSA: alu_res = a_ext;
            OP_PASSB: alu_res = b_ext;
            OP_ADD:   alu_res = a_ext + b_ext;
            OP_SUB:   alu_res = a_ext - b_ext;
            OP_MULT:  alu_res = a_ext * b_ext;
            OP_DIV,
            OP_MOD:   alu_err = 1'b1;
        endcase
    end

`ifdef IRP_DIV_EN
    localparam int CW = $clog2(OP_WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_WB} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [W-1:0]  da_q, da_d, db_q, db_d;
    logic [2:0]    dop_q, dop_d;
    logic [AW-1:0] dptr_q, dptr_d;
    logic [W:0]    shl, trial;
    logic [RW-1:0] q_ext, r_ext, dv_res;
    logic          dv_wr;

    assign div_start = xfer && div_op && (operand_b != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (div_start) state_d = S_DIV;
            S_DIV:   if (cnt_q == CW'(1)) state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
        dv_wr    = (state_q == S_WB);
        q_ext    = {{W{1'b0}}, quo_q};
        r_ext    = {{W{1'b0}}, rem_q};
        if (dop_q == OP_DIV)
            dv_res = (da_q[W-1] ^ db_q[W-1]) ? -q_ext : q_ext;
        else
            dv_res = da_q[W-1] ? -r_ext : r_ext;
    end

    // Restoring division on magnitudes; signs are fixed up in WB.
    always_comb begin
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        da_d   = da_q;
        db_d   = db_q;
        dop_d  = dop_q;
        dptr_d = dptr_q;
        shl    = {rem_q, quo_q[W-1]};
        trial  = shl - {1'b0, dvs_q};
        if (div_start) begin
            cnt_d  = CW'(OP_WIDTH);
            quo_d  = operand_a[W-1] ? -operand_a : operand_a;
            rem_d  = '0;
            dvs_d  = operand_b[W-1] ? -operand_b : operand_b;
            da_d   = operand_a;
            db_d   = operand_b;
            dop_d  = opcode;
            dptr_d = write_pointer;
        end else if (state_q == S_DIV) begin
            cnt_d = cnt_q - CW'(1);
            if (!trial[W]) begin
                rem_d = trial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shl[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            da_q   <= '0;
            db_q   <= '0;
            dop_q  <= '0;
            dptr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            da_q   <= da_d;
            db_q   <= db_d;
            dop_q  <= dop_d;
            dptr_q <= dptr_d;
        end
    end
`else
    assign in_ready  = 1'b1;
    assign div_start = 1'b0;
`endif

    always_comb begin
        stg_d     = '{vld: xfer && !div_start, err: alu_err, op: opcode,
                      a: operand_a, b: operand_b, res: alu_res};
        stg_ptr_d = write_pointer;
    end

    // Stage and divider writes are never in the same cycle.
    always_comb begin
        wr_en   = stg_q.vld;
        wr_ptr  = stg_ptr_q;
        entry_d = stg_q;
`ifdef IRP_DIV_EN
        if (dv_wr) begin
            wr_en   = 1'b1;
            wr_ptr  = dptr_q;
            entry_d = '{vld: 1'b1, err: 1'b0, op: dop_q,
                        a: da_q, b: db_q, res: dv_res};
        end
`endif
        wr_en         = wr_en && ({1'b0, wr_ptr} < DEPTH_W);
        wr_done_d     = wr_en;
        wr_done_ptr_d = wr_en ? wr_ptr : wr_done_ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_q         <= '0;
            stg_ptr_q     <= '0;
            wr_done_q     <= 1'b0;
            wr_done_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            stg_q         <= stg_d;
            stg_ptr_q     <= stg_ptr_d;
            wr_done_q     <= wr_done_d;
            wr_done_ptr_q <= wr_done_ptr_d;
            if (wr_en) mem_q[wr_ptr] <= entry_d;
        end
    end

    always_comb begin
        rd_e = '0;
        if ({1'b0, read_pointer} < DEPTH_W) rd_e = mem_q[read_pointer];
    end

    assign rd_opcode    = rd_e.op;
    assign rd_operand_a = rd_e.a;
    assign rd_operand_b = rd_e.b;
    assign rd_result    = rd_e.res;
    assign rd_valid     = rd_e.vld;
    assign rd_error     = rd_e.err;
    assign wr_done      = wr_done_q;
    assign wr_done_ptr  = wr_done_ptr_q;
endmodule
